// File: rtl/otter_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_if_pkg
//  Description : Shared types and constants for the OTTER instruction-fetch
//                sequencer (FSM states, fetch-buffer entry, PC stepping).
//  Revision    : 1.0  initial release
// ============================================================================
package otter_if_pkg;

    // State encodings, kept as explicit-width constants so the enum below
    // has a fixed, documented binary value for each state.
    localparam logic [1:0] c_ST_REQ      = 2'd0;
    localparam logic [1:0] c_ST_WAIT_RSP = 2'd1;
    localparam logic [1:0] c_ST_FLUSH    = 2'd2;

    typedef enum logic [1:0] {
        REQ      = c_ST_REQ,
        WAIT_RSP = c_ST_WAIT_RSP,
        FLUSH    = c_ST_FLUSH
    } if_state_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/otter_if_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : otter_if_fifo
//  Description : Small synchronous FIFO of {pc, instr} entries with flush.
//                Head entry is presented from storage; valid comes from the
//                registered occupancy count.
//  Revision    : 1.0  initial release
// ============================================================================
module otter_if_fifo
    import otter_if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic                     i_flush,
    input  wire if_entry_t                i_data,
    output if_entry_t                     o_head,
    output logic                          o_valid,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int               c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_DEPTH = (c_AW + 1)'(DEPTH);

    if_entry_t         r_mem [DEPTH];
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW:0]     r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_do_pop;
    logic              w_do_push;

    // Occupancy decode; a push into a full buffer is only taken when the
    // head leaves in the same cycle.
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == c_DEPTH);
        w_do_pop  = i_pop && !w_empty;
        w_do_push = i_push && (!w_full || w_do_pop);
    end

    // Pointer, count and storage update; flush only rewinds the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head presentation.
    always_comb begin
        o_head  = r_mem[r_rd_ptr];
        o_valid = !w_empty;
        o_count = r_count;
    end

endmodule
`default_nettype wire

// File: rtl/otter_if_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : otter_if_sequencer
//  Description : OTTER instruction-fetch sequencer. Issues one fetch at a
//                time from PC_CNT, steps the PC through its load port on
//                each grant, buffers {pc, instr} for decode and applies
//                branch/jump redirects, discarding the stale response.
//  Revision    : 1.0  initial release
// ============================================================================
module otter_if_sequencer
    import otter_if_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  wire logic        IF_CLK,
    input  wire logic        IF_RST,
    input  wire logic [31:0] PC_CNT,
    output logic             PC_LD,
    output logic [31:0]      PC_DIN,
    output logic             IMEM_REQ,
    output logic [31:0]      IMEM_ADDR,
    input  wire logic        IMEM_GNT,
    input  wire logic        IMEM_RVALID,
    input  wire logic [31:0] IMEM_RDATA,
    input  wire logic        REDIR_VALID,
    input  wire logic [31:0] REDIR_ADDR,
    output logic             INSTR_VALID,
    input  wire logic        INSTR_READY,
    output logic [31:0]      INSTR_DATA,
    output logic [31:0]      INSTR_PC
);

    localparam int               c_CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CW-1:0]  c_DEPTH_W = c_CW'(FIFO_DEPTH);

    if_state_t          r_state;
    if_state_t          w_state_nxt;
    logic [31:0]        r_addr;

    logic [c_CW-1:0]    w_count;
    logic               w_has_space;
    logic               w_req;
    logic               w_gnt_acc;
    logic               w_push;
    logic               w_pop;
    logic               w_head_valid;
    if_entry_t          w_push_data;
    if_entry_t          w_head;

    // Handshake qualification: a redirect or reset masks request and push.
    always_comb begin
        w_has_space = (w_count < c_DEPTH_W);
        w_req       = !IF_RST && !REDIR_VALID && (r_state == REQ) && w_has_space;
        w_gnt_acc   = w_req && IMEM_GNT;
        w_push      = !IF_RST && !REDIR_VALID && (r_state == WAIT_RSP) && IMEM_RVALID;
        w_pop       = w_head_valid && INSTR_READY;
        w_push_data = '{pc: r_addr, instr: IMEM_RDATA};
    end

    // Next-state logic; a redirect leaves FLUSH pending only while a
    // response is still owed.
    always_comb begin
        w_state_nxt = r_state;
        if (REDIR_VALID) begin
            w_state_nxt = ((r_state != REQ) && !IMEM_RVALID) ? FLUSH : REQ;
        end else begin
            case (r_state)
                REQ:      if (w_gnt_acc)   w_state_nxt = WAIT_RSP;
                WAIT_RSP: if (IMEM_RVALID) w_state_nxt = REQ;
                FLUSH:    if (IMEM_RVALID) w_state_nxt = REQ;
                default:                   w_state_nxt = REQ;
            endcase
        end
    end

    // PC load mux and fetch port; redirect target wins over sequential step.
    always_comb begin
        PC_LD     = 1'b0;
        PC_DIN    = '0;
        IMEM_REQ  = w_req;
        IMEM_ADDR = IF_RST ? '0 : align_word(PC_CNT);
        if (!IF_RST) begin
            if (REDIR_VALID) begin
                PC_LD  = 1'b1;
                PC_DIN = align_word(REDIR_ADDR);
            end else if (w_gnt_acc) begin
                PC_LD  = 1'b1;
                PC_DIN = PC_CNT + PC_STEP;
            end
        end
    end

    // State and outstanding-address registers.
    always_ff @(posedge IF_CLK or posedge IF_RST) begin
        if (IF_RST) begin
            r_state <= REQ;
            r_addr  <= RESET_ADDR;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt_acc) begin
                r_addr <= align_word(PC_CNT);
            end
        end
    end

    otter_if_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (IF_CLK),
        .rst     (IF_RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (REDIR_VALID),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_valid (w_head_valid),
        .o_count (w_count)
    );

    // Decode-side view of the buffer head.
    always_comb begin
        INSTR_VALID = w_head_valid;
        INSTR_DATA  = w_head.instr;
        INSTR_PC    = w_head.pc;
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_if_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otter_if_sequencer
//  Description : Directed self-checking bench for otter_if_sequencer with a
//                program-counter model and a simple instruction memory that
//                either auto-responds (GNT=1, RVALID one cycle later, data =
//                ~address) or is driven step by step.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_otter_if_sequencer;

    logic        IF_CLK = 1'b0;
    logic        IF_RST = 1'b0;
    logic [31:0] PC_CNT;
    logic        PC_LD;
    logic [31:0] PC_DIN;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        REDIR_VALID = 1'b0;
    logic [31:0] REDIR_ADDR  = '0;
    logic        INSTR_VALID;
    logic        INSTR_READY = 1'b0;
    logic [31:0] INSTR_DATA;
    logic [31:0] INSTR_PC;

    logic        auto_mem   = 1'b0;
    logic        man_gnt    = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata  = '0;
    logic        r_pend;
    logic [31:0] r_paddr;
    logic [31:0] r_pc;

    int checks = 0;
    int errors = 0;

    always #5 IF_CLK = ~IF_CLK;

    otter_if_sequencer #(
        .FIFO_DEPTH (2),
        .RESET_ADDR (32'h0)
    ) dut (
        .IF_CLK      (IF_CLK),
        .IF_RST      (IF_RST),
        .PC_CNT      (PC_CNT),
        .PC_LD       (PC_LD),
        .PC_DIN      (PC_DIN),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .REDIR_VALID (REDIR_VALID),
        .REDIR_ADDR  (REDIR_ADDR),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .INSTR_DATA  (INSTR_DATA),
        .INSTR_PC    (INSTR_PC)
    );

    // Program counter: resets to 0, loads PC_DIN on PC_LD.
    always @(posedge IF_CLK or posedge IF_RST) begin
        if (IF_RST)     r_pc <= '0;
        else if (PC_LD) r_pc <= PC_DIN;
    end
    assign PC_CNT = r_pc;

    // Auto memory: answers every accepted request one cycle later.
    always @(posedge IF_CLK or posedge IF_RST) begin
        if (IF_RST) begin
            r_pend  <= 1'b0;
            r_paddr <= '0;
        end else begin
            r_pend <= auto_mem && IMEM_REQ && IMEM_GNT;
            if (IMEM_REQ && IMEM_GNT) r_paddr <= IMEM_ADDR;
        end
    end
    assign IMEM_GNT    = auto_mem ? 1'b1    : man_gnt;
    assign IMEM_RVALID = auto_mem ? r_pend  : man_rvalid;
    assign IMEM_RDATA  = auto_mem ? ~r_paddr : man_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge IF_CLK);
        #1;
    endtask

    task automatic apply_reset();
        auto_mem    = 1'b0;
        man_gnt     = 1'b0;
        man_rvalid  = 1'b0;
        REDIR_VALID = 1'b0;
        INSTR_READY = 1'b0;
        IF_RST      = 1'b1;
        step();
        step();
        IF_RST = 1'b0;
        #1;
    endtask

    // Follow the stream until n entries have been consumed, checking the
    // address/data sequence and every sequential PC step along the way.
    task automatic collect(input int n, input logic [31:0] start, input int budget);
        logic [31:0] e;
        int got;
        int cyc;
        e   = start;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            if (INSTR_VALID && INSTR_READY) begin
                check("instr_pc", INSTR_PC, e);
                check("instr_data", INSTR_DATA, ~e);
                e = e + 32'd4;
                got++;
            end
            if (IMEM_REQ && IMEM_GNT) begin
                check("pc_ld_on_gnt", {31'b0, PC_LD}, 32'd1);
                check("pc_din_step", PC_DIN, PC_CNT + 32'd4);
            end else if (!REDIR_VALID) begin
                check("pc_ld_idle", {31'b0, PC_LD}, 32'd0);
            end
            step();
            cyc++;
        end
        check("collect_count", got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- 1: reset state, then sequential stream 0,4,8,C ----
        IF_RST   = 1'b1;
        auto_mem = 1'b1;
        step();
        step();
        check("rst_pc_ld", {31'b0, PC_LD}, 32'd0);
        check("rst_imem_req", {31'b0, IMEM_REQ}, 32'd0);
        check("rst_instr_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("rst_instr_data", INSTR_DATA, 32'd0);
        check("rst_instr_pc", INSTR_PC, 32'd0);
        INSTR_READY = 1'b1;
        IF_RST      = 1'b0;
        #1;
        check("t1_first_req", {31'b0, IMEM_REQ}, 32'd1);
        check("t1_first_addr", IMEM_ADDR, 32'h0);
        check("t1_first_pc_din", PC_DIN, 32'h4);
        collect(4, 32'h0, 40);

        // ---- 2: back-pressure fills the buffer, fetch stalls at 8 ----
        apply_reset();
        auto_mem = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("t2_req_stalled", {31'b0, IMEM_REQ}, 32'd0);
        check("t2_pc_frozen", PC_CNT, 32'h8);
        check("t2_head_valid", {31'b0, INSTR_VALID}, 32'd1);
        check("t2_head_pc", INSTR_PC, 32'h0);
        INSTR_READY = 1'b1;
        #1;
        collect(4, 32'h0, 40);

        // ---- 3: redirect during WAIT_RSP, stale response discarded ----
        apply_reset();
        check("t3_req", {31'b0, IMEM_REQ}, 32'd1);
        man_gnt = 1'b1;
        #1;
        check("t3_pc_ld", {31'b0, PC_LD}, 32'd1);
        check("t3_pc_din", PC_DIN, 32'h4);
        step();
        man_gnt    = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'h1111_0000;
        #1;
        check("t3_wait_no_req", {31'b0, IMEM_REQ}, 32'd0);
        step();
        man_rvalid = 1'b0;
        #1;
        check("t3_buf_valid", {31'b0, INSTR_VALID}, 32'd1);
        check("t3_buf_data", INSTR_DATA, 32'h1111_0000);
        man_gnt = 1'b1;
        step();
        man_gnt     = 1'b0;
        REDIR_VALID = 1'b1;
        REDIR_ADDR  = 32'h0000_0103;
        #1;
        check("t3_redir_ld", {31'b0, PC_LD}, 32'd1);
        check("t3_redir_din", PC_DIN, 32'h0000_0100);
        check("t3_redir_no_req", {31'b0, IMEM_REQ}, 32'd0);
        step();
        REDIR_VALID = 1'b0;
        #1;
        check("t3_flushed", {31'b0, INSTR_VALID}, 32'd0);
        check("t3_pc_target", PC_CNT, 32'h0000_0100);
        check("t3_flush_no_req", {31'b0, IMEM_REQ}, 32'd0);
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_BEEF;
        #1;
        check("t3_flush_no_ld", {31'b0, PC_LD}, 32'd0);
        step();
        man_rvalid = 1'b0;
        #1;
        check("t3_stale_dropped", {31'b0, INSTR_VALID}, 32'd0);
        check("t3_resume_req", {31'b0, IMEM_REQ}, 32'd1);
        check("t3_resume_addr", IMEM_ADDR, 32'h0000_0100);
        INSTR_READY = 1'b1;
        auto_mem    = 1'b1;
        #1;
        collect(2, 32'h0000_0100, 20);

        // ---- 4a: redirect in the same cycle as GNT ----
        apply_reset();
        man_gnt     = 1'b1;
        REDIR_VALID = 1'b1;
        REDIR_ADDR  = 32'h0000_0200;
        #1;
        check("t4a_no_req", {31'b0, IMEM_REQ}, 32'd0);
        check("t4a_ld", {31'b0, PC_LD}, 32'd1);
        check("t4a_din", PC_DIN, 32'h0000_0200);
        step();
        man_gnt     = 1'b0;
        REDIR_VALID = 1'b0;
        #1;
        check("t4a_req_target", {31'b0, IMEM_REQ}, 32'd1);
        check("t4a_addr_target", IMEM_ADDR, 32'h0000_0200);
        check("t4a_empty", {31'b0, INSTR_VALID}, 32'd0);
        auto_mem    = 1'b1;
        INSTR_READY = 1'b1;
        #1;
        collect(1, 32'h0000_0200, 20);

        // ---- 4b: redirect in the same cycle as RVALID ----
        apply_reset();
        man_gnt = 1'b1;
        step();
        man_gnt     = 1'b0;
        man_rvalid  = 1'b1;
        man_rdata   = 32'hBAD0_BAD0;
        REDIR_VALID = 1'b1;
        REDIR_ADDR  = 32'h0000_0300;
        #1;
        check("t4b_din", PC_DIN, 32'h0000_0300);
        step();
        man_rvalid  = 1'b0;
        REDIR_VALID = 1'b0;
        #1;
        check("t4b_no_flush_wait", {31'b0, IMEM_REQ}, 32'd1);
        check("t4b_addr", IMEM_ADDR, 32'h0000_0300);
        check("t4b_dropped", {31'b0, INSTR_VALID}, 32'd0);
        auto_mem    = 1'b1;
        INSTR_READY = 1'b1;
        #1;
        collect(1, 32'h0000_0300, 20);

        // ---- 5: redirect to the last word, PC wraps to 0 ----
        apply_reset();
        REDIR_VALID = 1'b1;
        REDIR_ADDR  = 32'hFFFF_FFFE;
        #1;
        check("t5_din_aligned", PC_DIN, 32'hFFFF_FFFC);
        step();
        REDIR_VALID = 1'b0;
        auto_mem    = 1'b1;
        INSTR_READY = 1'b1;
        #1;
        collect(2, 32'hFFFF_FFFC, 20);

        // ---- 6: asynchronous reset in the middle of WAIT_RSP ----
        apply_reset();
        auto_mem    = 1'b1;
        INSTR_READY = 1'b1;
        step();
        step();
        step();
        #1;
        IF_RST = 1'b1;
        #1;
        check("t6_pc_ld", {31'b0, PC_LD}, 32'd0);
        check("t6_pc_din", PC_DIN, 32'd0);
        check("t6_imem_req", {31'b0, IMEM_REQ}, 32'd0);
        check("t6_imem_addr", IMEM_ADDR, 32'd0);
        check("t6_instr_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("t6_instr_data", INSTR_DATA, 32'd0);
        check("t6_instr_pc", INSTR_PC, 32'd0);
        step();
        step();
        IF_RST = 1'b0;
        #1;
        collect(2, 32'h0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
